// File: rtl/uart_echo_engine_if.sv
// rtl/uart_echo_engine_if.sv - UART core RX/TX FIFO port bundle
interface uart_echo_engine_if #(
    parameter int DATA_BITS = 8
);
    logic                 rx_empty;
    logic [DATA_BITS-1:0] rx_data;
    logic                 rd_uart;
    logic                 tx_full;
    logic                 wr_uart;
    logic [DATA_BITS-1:0] tx_data;

    modport master (
        input  rx_empty, rx_data, tx_full,
        output rd_uart, wr_uart, tx_data
    );

    modport slave (
        output rx_empty, rx_data, tx_full,
        input  rd_uart, wr_uart, tx_data
    );
endinterface

// File: rtl/uart_echo_engine.sv
// rtl/uart_echo_engine.sv - RX-to-TX echo controller with selectable byte transform
module uart_echo_engine #(
    parameter int DATA_BITS = 8,
    parameter int OFFSET    = 1,
    parameter int CNT_BITS  = 16
) (
    input  logic                 clk_100MHz,
    input  logic                 reset_n,
    input  logic [1:0]           mode,
    input  logic                 auto_en,
    input  logic                 step,
    uart_echo_engine_if.master   fifo,
    output logic [DATA_BITS-1:0] last_rx,
    output logic [DATA_BITS-1:0] last_tx,
    output logic [CNT_BITS-1:0]  byte_count,
    output logic                 busy,
    output logic                 underrun
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        XFORM = 2'd1,
        SEND  = 2'd2
    } state_t;

    state_t               state;
    logic                 pending;
    logic [1:0]           mode_r;
    logic [DATA_BITS-1:0] byte_r;
    logic [DATA_BITS-1:0] result_r;
    logic [DATA_BITS-1:0] xform_val;
    logic [7:0]           low8;
    logic                 is_alpha;

    // Case detection looks only at the low 8 bits; wider words keep their upper bits.
    assign low8     = 8'(byte_r);
    assign is_alpha = ((low8 >= 8'h41) && (low8 <= 8'h5A)) ||
                      ((low8 >= 8'h61) && (low8 <= 8'h7A));

    always_comb begin
        xform_val = byte_r;
        case (mode_r)
            2'd1:    xform_val = byte_r + DATA_BITS'(OFFSET);
            2'd2:    xform_val = is_alpha ? (byte_r ^ DATA_BITS'(8'h20)) : byte_r;
            default: xform_val = byte_r;
        endcase
    end

    always_ff @(posedge clk_100MHz) begin
        if (!reset_n) begin
            state        <= IDLE;
            pending      <= 1'b0;
            mode_r       <= 2'd0;
            byte_r       <= '0;
            result_r     <= '0;
            fifo.rd_uart <= 1'b0;
            fifo.wr_uart <= 1'b0;
            fifo.tx_data <= '0;
            last_rx      <= '0;
            last_tx      <= '0;
            byte_count   <= '0;
            busy         <= 1'b0;
            underrun     <= 1'b0;
        end else begin
            fifo.rd_uart <= 1'b0;
            fifo.wr_uart <= 1'b0;
            if (step && !auto_en) begin
                pending <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if ((auto_en || pending) && !fifo.rx_empty) begin
                        byte_r       <= fifo.rx_data;
                        last_rx      <= fifo.rx_data;
                        mode_r       <= mode;
                        fifo.rd_uart <= 1'b1;
                        // A step coinciding with consumption becomes the next request.
                        pending      <= step && !auto_en;
                        busy         <= 1'b1;
                        state        <= XFORM;
                    end else begin
                        busy <= 1'b0;
                        if (pending && !auto_en && fifo.rx_empty) begin
                            pending  <= step;
                            underrun <= 1'b1;
                        end
                    end
                end

                XFORM: begin
                    result_r <= xform_val;
                    if (byte_count != {CNT_BITS{1'b1}}) begin
                        byte_count <= byte_count + 1'b1;
                    end
                    if (mode_r == 2'd3) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        state <= SEND;
                    end
                end

                SEND: begin
                    // busy stays high through the push cycle itself.
                    if (!fifo.tx_full) begin
                        fifo.wr_uart <= 1'b1;
                        fifo.tx_data <= result_r;
                        last_tx      <= result_r;
                        state        <= IDLE;
                    end
                end

                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_echo_engine.sv
// tb/tb_uart_echo_engine.sv - directed self-checking bench for uart_echo_engine
module tb_uart_echo_engine;
    logic        clk_100MHz = 1'b0;
    logic        reset_n;
    logic [1:0]  mode;
    logic        auto_en;
    logic        step;
    logic [7:0]  last_rx, last_tx, last_rx2, last_tx2;
    logic [15:0] byte_count;
    logic [1:0]  byte_count2;
    logic        busy, underrun, busy2, underrun2;

    int checks = 0;
    int failures = 0;
    int rd_count = 0;
    int wr_count = 0;
    int viol = 0;
    int diff = 0;
    int r0, w0;
    logic prev_rd = 1'b0;
    logic prev_wr = 1'b0;

    logic [7:0] fifo_mem [0:15];
    int wr_ptr = 0;
    int rd_ptr = 0;

    uart_echo_engine_if #(.DATA_BITS(8)) bus ();
    uart_echo_engine_if #(.DATA_BITS(8)) bus2 ();

    always #5 clk_100MHz = ~clk_100MHz;

    assign bus.rx_empty  = (rd_ptr == wr_ptr);
    assign bus.rx_data   = fifo_mem[rd_ptr[3:0]];
    assign bus2.rx_empty = bus.rx_empty;
    assign bus2.rx_data  = bus.rx_data;
    assign bus2.tx_full  = bus.tx_full;

    uart_echo_engine #(.DATA_BITS(8), .OFFSET(1), .CNT_BITS(16)) dut (
        .clk_100MHz (clk_100MHz),
        .reset_n    (reset_n),
        .mode       (mode),
        .auto_en    (auto_en),
        .step       (step),
        .fifo       (bus.master),
        .last_rx    (last_rx),
        .last_tx    (last_tx),
        .byte_count (byte_count),
        .busy       (busy),
        .underrun   (underrun)
    );

    uart_echo_engine #(.DATA_BITS(8), .OFFSET(1), .CNT_BITS(2)) dut_small (
        .clk_100MHz (clk_100MHz),
        .reset_n    (reset_n),
        .mode       (mode),
        .auto_en    (auto_en),
        .step       (step),
        .fifo       (bus2.master),
        .last_rx    (last_rx2),
        .last_tx    (last_tx2),
        .byte_count (byte_count2),
        .busy       (busy2),
        .underrun   (underrun2)
    );

    always @(posedge clk_100MHz) begin
        if (bus.rd_uart && (rd_ptr != wr_ptr)) rd_ptr <= rd_ptr + 1;
        if (bus.rd_uart) rd_count <= rd_count + 1;
        if (bus.wr_uart) wr_count <= wr_count + 1;
        if ((bus.rd_uart && bus.wr_uart) || (bus.rd_uart && prev_rd) || (bus.wr_uart && prev_wr))
            viol <= viol + 1;
        if ((bus2.rd_uart !== bus.rd_uart) || (bus2.wr_uart !== bus.wr_uart) || (bus2.tx_data !== bus.tx_data))
            diff <= diff + 1;
        prev_rd <= bus.rd_uart;
        prev_wr <= bus.wr_uart;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk_100MHz);
    endtask

    task automatic push(input logic [7:0] b);
        fifo_mem[wr_ptr[3:0]] = b;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset_n = 1'b0; mode = 2'd0; auto_en = 1'b1; step = 1'b0; bus.tx_full = 1'b0;
        push(8'h41);
        tick(1);
        check("rst_rd", {31'd0, bus.rd_uart}, 32'd0);
        check("rst_wr", {31'd0, bus.wr_uart}, 32'd0);
        check("rst_txd", {24'd0, bus.tx_data}, 32'd0);
        check("rst_last_rx", {24'd0, last_rx}, 32'd0);
        check("rst_last_tx", {24'd0, last_tx}, 32'd0);
        check("rst_count", {16'd0, byte_count}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_underrun", {31'd0, underrun}, 32'd0);
        tick(1);
        check("rst2_rd", {31'd0, bus.rd_uart}, 32'd0);
        auto_en = 1'b0; reset_n = 1'b1;
        tick(1);
        check("post_rst_rd", {31'd0, bus.rd_uart}, 32'd0);
        check("post_rst_busy", {31'd0, busy}, 32'd0);

        // manual step, add-offset mode
        mode = 2'd1; step = 1'b1;
        tick(1); step = 1'b0;
        check("m1_rd_early", {31'd0, bus.rd_uart}, 32'd0);
        tick(1);
        check("m1_rd", {31'd0, bus.rd_uart}, 32'd1);
        check("m1_last_rx", {24'd0, last_rx}, 32'h41);
        check("m1_busy", {31'd0, busy}, 32'd1);
        tick(1);
        check("m1_rd_once", {31'd0, bus.rd_uart}, 32'd0);
        check("m1_wr_early", {31'd0, bus.wr_uart}, 32'd0);
        tick(1);
        check("m1_wr", {31'd0, bus.wr_uart}, 32'd1);
        check("m1_txd", {24'd0, bus.tx_data}, 32'h42);
        check("m1_last_tx", {24'd0, last_tx}, 32'h42);
        check("m1_count", {16'd0, byte_count}, 32'd1);
        check("m1_busy_wr", {31'd0, busy}, 32'd1);
        tick(1);
        check("m1_wr_once", {31'd0, bus.wr_uart}, 32'd0);
        check("m1_idle", {31'd0, busy}, 32'd0);

        push(8'hFF); step = 1'b1;
        tick(1); step = 1'b0;
        tick(1);
        check("wrap_rd", {31'd0, bus.rd_uart}, 32'd1);
        check("wrap_last_rx", {24'd0, last_rx}, 32'hFF);
        tick(2);
        check("wrap_wr", {31'd0, bus.wr_uart}, 32'd1);
        check("wrap_txd", {24'd0, bus.tx_data}, 32'h00);
        check("wrap_count", {16'd0, byte_count}, 32'd2);
        tick(1);

        // auto drain with case toggle
        push(8'h61); push(8'h5A); push(8'h35);
        mode = 2'd2; auto_en = 1'b1;
        tick(1);
        check("cs_rd0", {31'd0, bus.rd_uart}, 32'd1);
        tick(2);
        check("cs_wr0", {31'd0, bus.wr_uart}, 32'd1);
        check("cs_txd0", {24'd0, bus.tx_data}, 32'h41);
        tick(1);
        check("cs_rd1", {31'd0, bus.rd_uart}, 32'd1);
        mode = 2'd0;
        tick(2);
        check("cs_wr1", {31'd0, bus.wr_uart}, 32'd1);
        check("cs_txd1", {24'd0, bus.tx_data}, 32'h7A);
        tick(3);
        check("cs_wr2", {31'd0, bus.wr_uart}, 32'd1);
        check("cs_txd2", {24'd0, bus.tx_data}, 32'h35);
        check("cs_count", {16'd0, byte_count}, 32'd5);
        tick(1);
        check("cs_busy_end", {31'd0, busy}, 32'd0);
        auto_en = 1'b0;

        // TX backpressure in SEND
        push(8'h30); bus.tx_full = 1'b1; step = 1'b1;
        tick(1); step = 1'b0;
        tick(1);
        check("bp_rd", {31'd0, bus.rd_uart}, 32'd1);
        tick(1);
        w0 = wr_count;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            check("bp_hold_wr", {31'd0, bus.wr_uart}, 32'd0);
            check("bp_hold_txd", {24'd0, bus.tx_data}, 32'h35);
        end
        bus.tx_full = 1'b0;
        tick(1);
        check("bp_wr", {31'd0, bus.wr_uart}, 32'd1);
        check("bp_txd", {24'd0, bus.tx_data}, 32'h30);
        tick(1);
        check("bp_wr_once", {31'd0, bus.wr_uart}, 32'd0);
        check("bp_wr_count", wr_count, w0 + 1);

        // underrun on an empty FIFO
        r0 = rd_count; step = 1'b1;
        tick(1); step = 1'b0;
        check("ur_before", {31'd0, underrun}, 32'd0);
        tick(1);
        check("ur_set", {31'd0, underrun}, 32'd1);
        tick(3);
        check("ur_no_rd", rd_count, r0);

        // three steps while busy collapse into one request
        push(8'h61); push(8'h70); push(8'h71);
        mode = 2'd1; bus.tx_full = 1'b1;
        r0 = rd_count; w0 = wr_count; step = 1'b1;
        tick(1); step = 1'b0;
        tick(1);
        check("ms_rd", {31'd0, bus.rd_uart}, 32'd1);
        tick(1);
        for (int i = 0; i < 3; i++) begin
            step = 1'b1; tick(1);
            step = 1'b0; tick(1);
            check("ms_busy", {31'd0, busy}, 32'd1);
        end
        bus.tx_full = 1'b0;
        tick(1);
        check("ms_wr", {31'd0, bus.wr_uart}, 32'd1);
        check("ms_txd", {24'd0, bus.tx_data}, 32'h62);
        tick(12);
        check("ms_rd_count", rd_count, r0 + 2);
        check("ms_wr_count", wr_count, w0 + 2);
        check("ms_last_rx", {24'd0, last_rx}, 32'h70);
        check("ms_last_tx", {24'd0, last_tx}, 32'h71);
        check("ms_left", {31'd0, bus.rx_empty}, 32'd0);
        check("ms_underrun_sticky", {31'd0, underrun}, 32'd1);

        // sink mode after reset, plus saturating small counter
        reset_n = 1'b0;
        tick(1);
        check("rst_clears_ur", {31'd0, underrun}, 32'd0);
        reset_n = 1'b1;
        push(8'h01); push(8'h02); push(8'h03);
        mode = 2'd3; r0 = rd_count; w0 = wr_count; auto_en = 1'b1;
        tick(1);
        check("sk_rd0", {31'd0, bus.rd_uart}, 32'd1);
        tick(1);
        check("sk_gap", {31'd0, bus.rd_uart}, 32'd0);
        tick(1);
        check("sk_rd1", {31'd0, bus.rd_uart}, 32'd1);
        tick(2);
        check("sk_rd2", {31'd0, bus.rd_uart}, 32'd1);
        tick(2);
        check("sk_rd3", {31'd0, bus.rd_uart}, 32'd1);
        tick(4);
        check("sk_rd_count", rd_count, r0 + 4);
        check("sk_wr_count", wr_count, w0);
        check("sk_count", {16'd0, byte_count}, 32'd4);
        check("sk_count_sat", {30'd0, byte_count2}, 32'd3);
        check("sk_last_rx", {24'd0, last_rx}, 32'h03);
        check("sk_busy", {31'd0, busy}, 32'd0);
        push(8'h04);
        tick(4);
        check("sk_count5", {16'd0, byte_count}, 32'd5);
        check("sk_count5_sat", {30'd0, byte_count2}, 32'd3);
        auto_en = 1'b0;

        // reset while in XFORM drops the byte
        mode = 2'd0; push(8'h55); w0 = wr_count; step = 1'b1;
        tick(1); step = 1'b0;
        tick(1);
        check("ab_rd", {31'd0, bus.rd_uart}, 32'd1);
        reset_n = 1'b0;
        tick(1);
        reset_n = 1'b1;
        tick(5);
        check("ab_no_wr", wr_count, w0);
        check("ab_busy", {31'd0, busy}, 32'd0);
        check("ab_txd", {24'd0, bus.tx_data}, 32'd0);

        check("protocol_violations", viol, 0);
        check("small_dut_divergence", diff, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/uart_echo_engine.md
# uart_echo_engine

Parametrised UART echo/transform controller that sits between the RX and TX FIFO ports of the UART core and the board-level display logic. It drains bytes from the RX FIFO on a manual step pulse from the button debouncer, or continuously in auto mode. It applies a selectable transform (pass, add offset, ASCII case toggle, sink) and writes the result to the TX FIFO, honouring TX backpressure. It also exposes the last received/transmitted bytes, a saturating byte counter and a sticky underrun flag for the LEDs.

## Interface
- DATA_BITS, 8, width of UART data word
- OFFSET, 1, constant added in mode 1 (modulo 2^DATA_BITS)
- CNT_BITS, 16, width of byte_count
- clk_100MHz  in  1  system clock; all logic on rising edge
- reset_n  in  1  synchronous, active-low reset
- mode  in  2  0 pass, 1 add OFFSET, 2 toggle ASCII case, 3 sink (read, no transmit)
- auto_en  in  1  1 = drain RX FIFO continuously; 0 = one byte per step
- step  in  1  single-cycle pulse (debounced tick); ignored while auto_en=1
- rx_empty  in  1  RX FIFO empty
- rx_data  in  DATA_BITS  RX FIFO head word, first-word-fall-through, valid while rx_empty=0
- tx_full  in  1  TX FIFO full
- rd_uart  out  1  one-cycle RX FIFO pop
- wr_uart  out  1  one-cycle TX FIFO push
- tx_data  out  DATA_BITS  word to TX FIFO, valid while wr_uart=1
- last_rx  out  DATA_BITS  last byte captured from RX
- last_tx  out  DATA_BITS  last byte pushed to TX
- byte_count  out  CNT_BITS  bytes consumed from RX, saturating
- busy  out  1  1 whenever state is not IDLE
- underrun  out  1  sticky: a step arrived with nothing to read

## Operation
- All outputs are registered. Reset (reset_n=0 at a clock edge) values: state IDLE, rd_uart=0, wr_uart=0, tx_data=0, last_rx=0, last_tx=0, byte_count=0, busy=0, underrun=0, pending=0.
- go = auto_en | pending. pending is set by step=1 when auto_en=0. It holds at most one request; further steps while pending=1 are discarded. pending clears when IDLE consumes it.
- IDLE: if go and rx_empty=0, capture rx_data into last_rx and the internal reg, latch mode into mode_r, assert rd_uart next cycle, clear pending, go to XFORM. If pending=1, auto_en=0 and rx_empty=1, clear pending and set underrun. A step arriving in the same cycle IDLE consumes pending is treated as the next request.
- XFORM: compute the result from mode_r, then go to SEND.
  - mode 0: result = byte.
  - mode 1: result = byte + OFFSET, truncated to DATA_BITS (0xFF+1 = 0x00).
  - mode 2: if byte is in 0x41–0x5A or 0x61–0x7A, XOR with 0x20; otherwise unchanged. Bits above bit 7 pass through.
  - mode 3: no result; go to IDLE directly and count the byte.
- SEND: wait while tx_full=1, holding tx_data stable. When tx_full=0, assert wr_uart next cycle with tx_data = result, load last_tx, and return to IDLE.
- byte_count increments once per byte on leaving XFORM (all modes) and saturates at 2^CNT_BITS−1.
- A mode change mid-byte does not affect the byte in flight. Changing auto_en mid-byte also leaves the in-flight byte unaffected.
- Reset mid-operation aborts the byte. If rd_uart has already fired, that byte is lost. No wr_uart is issued after reset.

## Timing
- Trigger seen in IDLE at cycle n → rd_uart=1 in cycle n+1 → wr_uart=1 in cycle n+3 (tx_full=0). Each extra tx_full cycle in SEND adds one cycle.
- Steady-state auto throughput: one byte per 3 cycles. Mode 3: one byte per 2 cycles.
- rd_uart and wr_uart are never high for more than one consecutive cycle per byte. They are never high in the same cycle.
- busy=1 from cycle n+1 until the cycle wr_uart is asserted (inclusive of XFORM/SEND).
- underrun sets on the edge after the empty-consumed request and clears only on reset.

## Test plan
- Reset: hold reset_n=0 for 2 cycles with rx_empty=0 and auto_en=1 → all outputs 0; no rd_uart or wr_uart during reset or in the first cycle after release.
- Manual mode 1, rx_data=0x41, single step → rd_uart at +1, wr_uart at +3 with tx_data=0x42; last_rx=0x41, last_tx=0x42, byte_count=1. Repeat with rx_data=0xFF → tx_data=0x00.
- Mode 2, auto_en=1, FIFO holding "aZ5" (0x61,0x5A,0x35) → TX sequence 0x41,0x7A,0x35 at 3-cycle spacing; byte_count=3; then busy=0.
- Backpressure: tx_full=1 for 10 cycles during SEND → wr_uart stays 0 and tx_data is stable. wr_uart fires exactly once, one cycle after tx_full falls.
- Step with rx_empty=1 → no rd_uart, underrun=1. Then three steps while busy → only one extra byte processed.
- Mode 3 with 4 bytes in auto → 4 rd_uart pulses, 0 wr_uart, byte_count=4. Separately, with CNT_BITS=2 and 5 bytes → byte_count=3. Reset asserted in XFORM → no wr_uart follows.
